// File: rtl/mem_stage_lsu_if.sv
// Data bus between the MEM-stage LSU (master) and the memory system (slave):
// registered request side, grant accepts the request, rvalid returns read data.
interface mem_stage_lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one bus access per EX/MEM op, >=3 cycles (IDLE,REQ,DONE) plus WAIT for loads.
// Pipeline is held via stall until the access completes or times out; illegal accesses are dropped at once.
module mem_stage_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [2:0]      funct3,
  input  logic [63:0]     addr,
  input  logic [63:0]     wdata,
  output logic            stall,
  output logic [63:0]     load_data,
  output logic            misaligned,
  output logic            bus_error,
  mem_stage_lsu_if.master bus
);

  localparam int CW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [63:0]   r_addr;
  logic [63:0]   r_wdata;
  logic [7:0]    r_wstrb;
  logic [2:0]    r_f3;
  logic [2:0]    r_off;
  logic [63:0]   r_load;

  logic          w_any;
  logic          w_bad_f3;
  logic          w_unaligned;
  logic          w_bad;
  logic          w_ok;
  logic          w_busy;
  logic          w_timeout;
  logic [63:0]   w_st_data;
  logic [7:0]    w_st_strb;
  logic [63:0]   w_sel;
  logic [63:0]   w_ld_ext;

  assign w_any     = MemRead | MemWrite;
  assign w_bad_f3  = MemWrite ? funct3[2] : (funct3 == 3'b111);
  assign w_bad     = w_any & ((MemRead & MemWrite) | w_bad_f3 | w_unaligned);
  assign w_ok      = w_any & ~w_bad;
  assign w_busy    = (r_state == S_REQ) || (r_state == S_WAIT);
  assign w_timeout = w_busy && (r_cnt == CW'(TIMEOUT));

  always_comb begin
    case (funct3[1:0])
      2'b01:   w_unaligned = addr[0];
      2'b10:   w_unaligned = |addr[1:0];
      2'b11:   w_unaligned = |addr[2:0];
      default: w_unaligned = 1'b0;
    endcase
  end

  // Store data is replicated across the word so every legal offset sees it on its lanes.
  always_comb begin
    w_st_data = wdata;
    w_st_strb = 8'hFF;
    case (funct3[1:0])
      2'b00: begin
        w_st_data = {8{wdata[7:0]}};
        w_st_strb = 8'h01 << addr[2:0];
      end
      2'b01: begin
        w_st_data = {4{wdata[15:0]}};
        w_st_strb = 8'h03 << addr[2:0];
      end
      2'b10: begin
        w_st_data = {2{wdata[31:0]}};
        w_st_strb = 8'h0F << addr[2:0];
      end
      default: ;
    endcase
  end

  assign w_sel = bus.mem_rdata >> {r_off, 3'b000};

  always_comb begin
    case (r_f3)
      3'b000:  w_ld_ext = {{56{w_sel[7]}},  w_sel[7:0]};
      3'b001:  w_ld_ext = {{48{w_sel[15]}}, w_sel[15:0]};
      3'b010:  w_ld_ext = {{32{w_sel[31]}}, w_sel[31:0]};
      3'b100:  w_ld_ext = {56'd0, w_sel[7:0]};
      3'b101:  w_ld_ext = {48'd0, w_sel[15:0]};
      3'b110:  w_ld_ext = {32'd0, w_sel[31:0]};
      default: w_ld_ext = w_sel;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Timeout wins over a grant or rvalid arriving in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_ok) w_next = S_REQ;
      S_REQ: begin
        if (w_timeout)        w_next = S_DONE;
        else if (bus.mem_gnt) w_next = r_we ? S_DONE : S_WAIT;
      end
      S_WAIT: if (w_timeout || bus.mem_rvalid) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // IDLE decodes are gated by reset so stall/misaligned stay low while reset is held.
  always_comb begin
    stall       = 1'b0;
    misaligned  = 1'b0;
    bus.mem_req = 1'b0;
    bus_error   = w_timeout;
    case (r_state)
      S_IDLE: begin
        stall      = reset & w_ok;
        misaligned = reset & w_bad;
      end
      S_REQ: begin
        stall       = 1'b1;
        bus.mem_req = ~w_timeout;
      end
      S_WAIT:  stall = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_f3    <= '0;
      r_off   <= '0;
      r_load  <= '0;
    end else begin
      r_cnt <= w_busy ? r_cnt + CW'(1) : '0;
      if (r_state == S_IDLE && w_ok) begin
        r_addr  <= {addr[63:3], 3'b000};
        r_we    <= MemWrite;
        r_wdata <= w_st_data;
        r_wstrb <= MemWrite ? w_st_strb : 8'h00;
        r_f3    <= funct3;
        r_off   <= addr[2:0];
      end
      if (w_timeout) begin
        r_load <= '0;
      end else if (r_state == S_WAIT && bus.mem_rvalid) begin
        r_load <= w_ld_ext;
      end
    end
  end

  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_wstrb = r_wstrb;
  assign load_data     = r_load;

endmodule
